// File: rtl/sevseg_fx_pkg.sv
// sevseg_fx_pkg: segment constants, sizes and the pattern ROM for the seven-segment effects engine.
package sevseg_fx_pkg;
    localparam int NUM_PATTERNS = 16;
    localparam int STEPS = 8;
    localparam int PAT_W = $clog2(NUM_PATTERNS);
    localparam int STEP_W = $clog2(STEPS);
    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;
    localparam logic [6:0] SEG_G = 7'h40;
    // Rows: chase, cw, ccw, snake, fill, scans, warns, pseudo-random variants.
    localparam logic [6:0] ROM [NUM_PATTERNS][STEPS] = '{
        '{SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, 7'h00},
        '{SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_A, SEG_B},
        '{SEG_A, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_F},
        '{SEG_A, SEG_B, SEG_G, SEG_E, SEG_D, SEG_C, SEG_G, SEG_F},
        '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00},
        '{7'h01, 7'h40, 7'h08, 7'h40, 7'h01, 7'h40, 7'h08, 7'h00},
        '{7'h30, 7'h06, 7'h30, 7'h06, 7'h30, 7'h06, 7'h30, 7'h06},
        '{7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00},
        '{7'h49, 7'h36, 7'h49, 7'h36, 7'h49, 7'h36, 7'h49, 7'h36},
        '{7'h5B, 7'h24, 7'h6D, 7'h12, 7'h3F, 7'h40, 7'h76, 7'h09},
        '{7'h33, 7'h4C, 7'h1E, 7'h61, 7'h07, 7'h78, 7'h55, 7'h2A},
        '{7'h03, 7'h06, 7'h0C, 7'h18, 7'h30, 7'h21, 7'h03, 7'h06},
        '{7'h09, 7'h12, 7'h24, 7'h09, 7'h12, 7'h24, 7'h09, 7'h12},
        '{7'h7F, 7'h3F, 7'h1F, 7'h0F, 7'h07, 7'h03, 7'h01, 7'h00},
        '{7'h40, 7'h49, 7'h7F, 7'h49, 7'h40, 7'h00, 7'h40, 7'h00},
        '{7'h2D, 7'h52, 7'h19, 7'h66, 7'h0B, 7'h74, 7'h3C, 7'h43}
    };
    function automatic logic [6:0] seg_lookup(input logic [PAT_W-1:0] p, input logic [STEP_W-1:0] s);
        return ROM[p][s];
    endfunction
endpackage

// File: rtl/sevseg_fx_engine_if.sv
// sevseg_fx_engine_if: control inputs and display outputs of the effects engine.
interface sevseg_fx_engine_if #(parameter int PRESCALE_W = 8);
    logic                  i_en;
    logic [PRESCALE_W-1:0] i_div;
    logic [3:0]            i_sel;
    logic                  i_auto;
    logic [3:0]            i_repeat;
    logic                  i_reverse;
    logic                  i_invert;
    logic [6:0]            o_segment;
    logic                  o_dp;
    logic [2:0]            o_step;
    logic [3:0]            o_pattern;
    logic                  o_frame_done;
    modport master (output i_en, i_div, i_sel, i_auto, i_repeat, i_reverse, i_invert,
                    input o_segment, o_dp, o_step, o_pattern, o_frame_done);
    modport slave (input i_en, i_div, i_sel, i_auto, i_repeat, i_reverse, i_invert,
                   output o_segment, o_dp, o_step, o_pattern, o_frame_done);
endinterface

// File: rtl/fx_prescaler.sv
// fx_prescaler: enable-gated divider producing one tick every i_div+1 enabled cycles.
module fx_prescaler #(parameter int PRESCALE_W = 8) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_div,
    output logic                  o_tick
);
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    // >= so that lowering i_div below the running count ticks at once
    always_comb begin
        o_tick = i_en && (cnt_q >= i_div);
        cnt_d = !i_en ? cnt_q : o_tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sevseg_fx_engine.sv
// sevseg_fx_engine: seven-segment animation engine with frame-aligned pattern switching and auto-cycle.
module sevseg_fx_engine
    import sevseg_fx_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input logic i_clk,
    input logic i_rst,
    sevseg_fx_engine_if.slave bus
);
    logic              tick, wrap;
    logic [STEP_W-1:0] step_q, step_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [3:0]        rep_q, rep_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d, fd_q, fd_d;
    fx_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(bus.i_en), .i_div(bus.i_div), .o_tick(tick)
    );
    always_comb begin
        wrap = tick && (bus.i_reverse ? step_q == '0 : step_q == STEP_W'(STEPS - 1));
        step_d = !tick ? step_q : bus.i_reverse ? step_q - STEP_W'(1) : step_q + STEP_W'(1);
        pattern_d = pattern_q;
        rep_d = rep_q;
        if (!bus.i_auto) begin
            rep_d = '0;
            pattern_d = wrap ? bus.i_sel : pattern_q;
        end else if (wrap) begin
            // >= so a lowered repeat count advances on the next wrap
            pattern_d = (rep_q >= bus.i_repeat) ? pattern_q + PAT_W'(1) : pattern_q;
            rep_d = (rep_q >= bus.i_repeat) ? '0 : rep_q + 4'd1;
        end
        dp_d = !bus.i_auto && (bus.i_sel != pattern_q);
        fd_d = wrap;
        seg_d = seg_lookup(pattern_q, step_q) ^ {7{bus.i_invert}};
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_q <= '0;
            pattern_q <= '0;
            rep_q <= '0;
            seg_q <= '0;
            dp_q <= 1'b0;
            fd_q <= 1'b0;
        end else begin
            step_q <= step_d;
            pattern_q <= pattern_d;
            rep_q <= rep_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
            fd_q <= fd_d;
        end
    end
    assign bus.o_segment = seg_q;
    assign bus.o_dp = dp_q;
    assign bus.o_step = step_q;
    assign bus.o_pattern = pattern_q;
    assign bus.o_frame_done = fd_q;
endmodule

// File: tb/tb_sevseg_fx_engine.sv
// tb_sevseg_fx_engine: directed checks of the effects engine against hand-computed values.
module tb_sevseg_fx_engine;
    logic clk, rst;
    int tests, fails;
    logic [6:0] chase [8];
    sevseg_fx_engine_if #(.PRESCALE_W(8)) bus ();
    sevseg_fx_engine #(.PRESCALE_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset;
        bus.i_en = 1'b1; bus.i_div = 8'd0; bus.i_sel = 4'd0; bus.i_auto = 1'b0;
        bus.i_repeat = 4'd0; bus.i_reverse = 1'b0; bus.i_invert = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask
    task automatic test_reset;
        bus.i_en = 1'b1; bus.i_div = 8'd0; bus.i_sel = 4'd3; bus.i_auto = 1'b0;
        bus.i_repeat = 4'd0; bus.i_reverse = 1'b0; bus.i_invert = 1'b1;
        rst = 1'b1;
        cyc(3);
        tests++; if (bus.o_segment !== 7'h00) begin fails++; $display("FAIL reset_seg got %h want 00", bus.o_segment); end
        tests++; if (bus.o_step !== 3'd0) begin fails++; $display("FAIL reset_step got %0d want 0", bus.o_step); end
        tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL reset_pattern got %0d want 0", bus.o_pattern); end
        tests++; if (bus.o_dp !== 1'b0) begin fails++; $display("FAIL reset_dp got %b want 0", bus.o_dp); end
        tests++; if (bus.o_frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", bus.o_frame_done); end
    endtask
    task automatic test_chase;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            tests++; if (bus.o_step !== 3'(k % 8)) begin fails++; $display("FAIL chase_step k=%0d got %0d want %0d", k, bus.o_step, k % 8); end
            tests++; if (bus.o_segment !== chase[(k - 1) % 8]) begin fails++; $display("FAIL chase_seg k=%0d got %h want %h", k, bus.o_segment, chase[(k - 1) % 8]); end
            tests++; if (bus.o_frame_done !== (k % 8 == 0)) begin fails++; $display("FAIL chase_fd k=%0d got %b want %b", k, bus.o_frame_done, k % 8 == 0); end
        end
    endtask
    task automatic test_prescale_freeze;
        do_reset();
        bus.i_div = 8'd3;
        cyc(3);
        tests++; if (bus.o_step !== 3'd0) begin fails++; $display("FAIL pre_step3 got %0d want 0", bus.o_step); end
        cyc(1);
        tests++; if (bus.o_step !== 3'd1) begin fails++; $display("FAIL pre_step4 got %0d want 1", bus.o_step); end
        cyc(4);
        tests++; if (bus.o_step !== 3'd2) begin fails++; $display("FAIL pre_step8 got %0d want 2", bus.o_step); end
        bus.i_en = 1'b0;
        cyc(10);
        tests++; if (bus.o_step !== 3'd2) begin fails++; $display("FAIL freeze_step got %0d want 2", bus.o_step); end
        tests++; if (bus.o_segment !== 7'h04) begin fails++; $display("FAIL freeze_seg got %h want 04", bus.o_segment); end
        bus.i_invert = 1'b1;
        cyc(1);
        tests++; if (bus.o_segment !== 7'h7B) begin fails++; $display("FAIL freeze_inv got %h want 7b", bus.o_segment); end
        tests++; if (bus.o_step !== 3'd2) begin fails++; $display("FAIL freeze_step2 got %0d want 2", bus.o_step); end
    endtask
    task automatic test_manual_switch;
        do_reset();
        cyc(3);
        tests++; if (bus.o_dp !== 1'b0) begin fails++; $display("FAIL man_dp_before got %b want 0", bus.o_dp); end
        bus.i_sel = 4'd5;
        for (int k = 4; k <= 7; k++) begin
            cyc(1);
            tests++; if (bus.o_dp !== 1'b1) begin fails++; $display("FAIL man_dp k=%0d got %b want 1", k, bus.o_dp); end
            tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL man_pat_hold k=%0d got %0d want 0", k, bus.o_pattern); end
        end
        cyc(1);
        tests++; if (bus.o_pattern !== 4'd5) begin fails++; $display("FAIL man_pat_wrap got %0d want 5", bus.o_pattern); end
        tests++; if (bus.o_frame_done !== 1'b1) begin fails++; $display("FAIL man_fd got %b want 1", bus.o_frame_done); end
        cyc(1);
        tests++; if (bus.o_dp !== 1'b0) begin fails++; $display("FAIL man_dp_after got %b want 0", bus.o_dp); end
        tests++; if (bus.o_pattern !== 4'd5) begin fails++; $display("FAIL man_pat_after got %0d want 5", bus.o_pattern); end
    endtask
    task automatic test_auto;
        do_reset();
        bus.i_auto = 1'b1; bus.i_repeat = 4'd1; bus.i_sel = 4'd7;
        cyc(15);
        tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL auto_p15 got %0d want 0", bus.o_pattern); end
        tests++; if (bus.o_dp !== 1'b0) begin fails++; $display("FAIL auto_dp got %b want 0", bus.o_dp); end
        cyc(1);
        tests++; if (bus.o_pattern !== 4'd1) begin fails++; $display("FAIL auto_p16 got %0d want 1", bus.o_pattern); end
        cyc(15);
        tests++; if (bus.o_pattern !== 4'd1) begin fails++; $display("FAIL auto_p31 got %0d want 1", bus.o_pattern); end
        cyc(1);
        tests++; if (bus.o_pattern !== 4'd2) begin fails++; $display("FAIL auto_p32 got %0d want 2", bus.o_pattern); end
        do_reset();
        bus.i_sel = 4'd15;
        cyc(8);
        tests++; if (bus.o_pattern !== 4'd15) begin fails++; $display("FAIL preload got %0d want 15", bus.o_pattern); end
        bus.i_auto = 1'b1; bus.i_repeat = 4'd0;
        cyc(7);
        tests++; if (bus.o_pattern !== 4'd15) begin fails++; $display("FAIL wrap15_hold got %0d want 15", bus.o_pattern); end
        cyc(1);
        tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL wrap15 got %0d want 0", bus.o_pattern); end
        do_reset();
        bus.i_auto = 1'b1; bus.i_repeat = 4'd3;
        cyc(16);
        tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL lower_hold got %0d want 0", bus.o_pattern); end
        bus.i_repeat = 4'd1;
        cyc(8);
        tests++; if (bus.o_pattern !== 4'd1) begin fails++; $display("FAIL lower_adv got %0d want 1", bus.o_pattern); end
    endtask
    task automatic test_reverse;
        do_reset();
        bus.i_reverse = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            tests++; if (bus.o_step !== 3'((16 - k) % 8)) begin fails++; $display("FAIL rev_step k=%0d got %0d want %0d", k, bus.o_step, (16 - k) % 8); end
            tests++; if (bus.o_frame_done !== ((16 - k) % 8 == 7)) begin fails++; $display("FAIL rev_fd k=%0d got %b want %b", k, bus.o_frame_done, (16 - k) % 8 == 7); end
        end
        cyc(7);
        tests++; if (bus.o_step !== 3'd0) begin fails++; $display("FAIL rev_step16 got %0d want 0", bus.o_step); end
        bus.i_invert = 1'b1;
        cyc(1);
        tests++; if (bus.o_segment !== 7'h7E) begin fails++; $display("FAIL rev_inv got %h want 7e", bus.o_segment); end
    endtask
    task automatic test_mid_reset;
        do_reset();
        bus.i_sel = 4'd9;
        cyc(8);
        bus.i_auto = 1'b1; bus.i_repeat = 4'd5;
        cyc(20);
        tests++; if (bus.o_pattern !== 4'd9) begin fails++; $display("FAIL mid_pat got %0d want 9", bus.o_pattern); end
        tests++; if (bus.o_step !== 3'd4) begin fails++; $display("FAIL mid_step got %0d want 4", bus.o_step); end
        rst = 1'b1; bus.i_repeat = 4'd2; bus.i_sel = 4'd0;
        cyc(1);
        tests++; if ({bus.o_segment, bus.o_dp, bus.o_step, bus.o_pattern, bus.o_frame_done} !== 16'd0)
            begin fails++; $display("FAIL mid_rst_outs got seg=%h dp=%b step=%0d pat=%0d fd=%b want all 0", bus.o_segment, bus.o_dp, bus.o_step, bus.o_pattern, bus.o_frame_done); end
        rst = 1'b0;
        cyc(1);
        tests++; if (bus.o_step !== 3'd1) begin fails++; $display("FAIL restart_step got %0d want 1", bus.o_step); end
        tests++; if (bus.o_segment !== 7'h01) begin fails++; $display("FAIL restart_seg got %h want 01", bus.o_segment); end
        cyc(7);
        tests++; if (bus.o_pattern !== 4'd0) begin fails++; $display("FAIL restart_rep got %0d want 0", bus.o_pattern); end
        cyc(16);
        tests++; if (bus.o_pattern !== 4'd1) begin fails++; $display("FAIL restart_adv got %0d want 1", bus.o_pattern); end
    endtask
    initial begin
        tests = 0; fails = 0;
        chase = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00};
        test_reset();
        test_chase();
        test_prescale_freeze();
        test_manual_switch();
        test_auto();
        test_reverse();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sevseg_fx_engine.md
Name: sevseg_fx_engine

Overview:
Parametrised seven-segment effects engine, the successor to the fixed mod-8 pattern selector.
- Built-in prescaler sets the animation speed.
- Pattern switches are deferred to frame boundaries, so no pattern is torn mid-animation.
- Adds auto-cycle mode with a programmable repeat count, reverse playback and output inversion.
- Sits between the chip I/O pins and the 7-segment display; it is the only driver of the segment outputs.

Parameters:
PRESCALE_W, 8, width of the prescaler divide value i_div and of the prescaler counter
NUM_PATTERNS, 16, number of patterns in the ROM; the pattern index is 4 bits wide
STEPS, 8, steps per frame; the step index is 3 bits wide; fixed power of two

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  prescaler enable; low freezes the animation
i_div  in  PRESCALE_W  tick period minus 1
i_sel  in  4  requested pattern (manual mode)
i_auto  in  1  1 = auto-cycle patterns, 0 = manual
i_repeat  in  4  auto mode: frames per pattern minus 1
i_reverse  in  1  1 = steps decrement
i_invert  in  1  invert the segment outputs (common-anode display)
o_segment  out  7  {g,f,e,d,c,b,a}; bit0 = a
o_dp  out  1  manual mode: a pattern change is pending
o_step  out  3  current step register
o_pattern  out  4  current pattern register
o_frame_done  out  1  one-cycle pulse on a frame wrap

Behaviour:
- Reset (synchronous, overrides all inputs): prescaler counter, step, pattern, repeat counter, o_segment, o_dp and o_frame_done all go to 0. o_segment stays blank (0, not inverted) until the first clock after reset release.
- Prescaler:
  - Counts while i_en = 1.
  - tick = i_en && (cnt >= i_div). On tick, cnt clears to 0; otherwise cnt increments.
  - i_div = 0 gives a tick every enabled cycle.
  - Using >= means that lowering i_div below the current count produces an immediate tick.
  - i_en = 0 holds cnt and produces no ticks.
- Step:
  - On tick, step increments by 1 mod 8 (i_reverse = 0) or decrements by 1 mod 8 (i_reverse = 1).
  - Direction is sampled on each tick; toggling it mid-frame takes effect on the next tick.
- Frame boundary (wrap):
  - wrap = tick && (step == 7 with i_reverse = 0, or step == 0 with i_reverse = 1).
  - o_frame_done is registered: it is high for exactly the one cycle in which the wrapped step value is visible on o_step.
- Pattern register: changes only on wrap.
  - Manual mode (i_auto = 0): load the i_sel value present in the wrap cycle. The repeat counter is held at 0.
  - Auto mode (i_auto = 1):
    - If rep == i_repeat: pattern <= pattern + 1 mod 16 and rep <= 0.
    - Otherwise: rep <= rep + 1.
    - If i_repeat is lowered below rep, the next wrap advances the pattern.
  - Switching from auto to manual: rep clears immediately; i_sel loads at the next wrap.
- o_dp: registered value of (!i_auto && i_sel != pattern).
- o_segment:
  - Registered value of ROM[pattern][step] XOR {7{i_invert}}.
  - One-cycle latency behind o_step/o_pattern.
  - Keeps updating while i_en = 0, so i_invert still acts during a freeze.
- ROM pattern 0, single-segment chase, steps 0..7: 01, 02, 04, 08, 10, 20, 40, 00 (hex).
- The other 15 patterns are fixed tables in the package: the cw/ccw, snake, scans, warn and pseudo-random effects.
- Pattern selection is never glitchy. Simultaneous i_sel change and wrap: the value sampled in the wrap cycle wins.

Decomposition:
- sevseg_fx_pkg holds:
  - segment bit constants SEG_A..SEG_G
  - NUM_PATTERNS and STEPS
  - the pattern ROM as a constant array plus a lookup function
- Sub-module fx_prescaler (PRESCALE_W) produces tick; it holds the prescaler counter and the i_en/i_div logic.
- Step, pattern, repeat and output registers stay in sevseg_fx_engine.

Test Plan:
1. Reset, i_div=0, i_sel=0, manual, i_en=1 -> o_segment = 01,02,04,08,10,20,40,00 repeating one per cycle; o_frame_done high every 8th cycle, coincident with o_step = 0.
2. i_div=3 -> o_step advances every 4 cycles. Drop i_en for 10 cycles -> o_step frozen. Toggle i_invert during the freeze -> o_segment flips to the complement within 1 cycle.
3. Manual, pattern 0 at step 3, set i_sel=5 -> o_dp=1 from the next cycle until the wrap; o_pattern changes 0->5 in the o_frame_done cycle only; o_dp=0 afterwards.
4. i_auto=1, i_repeat=1, i_div=0 -> o_pattern increments every 16 cycles (2 frames); preload pattern 15 -> next advance gives 0.
5. i_reverse=1 with pattern 0 -> o_step sequence 7,6,...,0,7; o_frame_done on the 0->7 wrap; with i_invert=1, step 0 shows 7E.
6. Assert i_rst for one cycle mid-frame (pattern 9, step 4, rep 2) -> next cycle all outputs and state are 0; animation restarts from pattern 0, step 0.
